// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - 2:1 round-robin AXI4 read-channel arbiter, one outstanding burst
module axi_rd_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [ID_WIDTH-1:0]   s_arid,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [ID_WIDTH-1:0]   s_rid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic                  prot_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t              state;
    logic                grant;
    logic                last_grant;
    logic [7:0]          len_reg;
    logic [7:0]          beat_cnt;
    logic [ID_WIDTH-1:0] gid;
    logic                in_addr;
    logic                in_data;
    logic                ar_hs;
    logic                r_hs;

    assign gid     = ID_WIDTH'(grant);
    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);
    assign ar_hs   = s_arvalid && s_arready;
    assign r_hs    = s_rvalid && s_rready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            len_reg    <= 8'd0;
            beat_cnt   <= 8'd0;
            prot_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        // On contention the master that did not win last time gets the bus.
                        if (m0_arvalid && m1_arvalid)
                            grant <= ~last_grant;
                        else
                            grant <= m1_arvalid;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        len_reg  <= s_arlen;
                        beat_cnt <= 8'd0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if ((s_rlast != (beat_cnt == len_reg)) || (s_rid != gid))
                            prot_err <= 1'b1;
                        if (s_rlast) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // AR and R paths are pure muxes gated by state; no datapath registers.
    always_comb begin
        s_arid     = gid;
        s_araddr   = grant ? m1_araddr  : m0_araddr;
        s_arlen    = grant ? m1_arlen   : m0_arlen;
        s_arsize   = grant ? m1_arsize  : m0_arsize;
        s_arburst  = grant ? m1_arburst : m0_arburst;
        s_arvalid  = in_addr && (grant ? m1_arvalid : m0_arvalid);
        m0_arready = in_addr && !grant && s_arready;
        m1_arready = in_addr &&  grant && s_arready;

        s_rready   = in_data && (grant ? m1_rready : m0_rready);
        m0_rvalid  = in_data && !grant && s_rvalid;
        m1_rvalid  = in_data &&  grant && s_rvalid;
        m0_rdata   = (in_data && !grant) ? s_rdata : '0;
        m1_rdata   = (in_data &&  grant) ? s_rdata : '0;
        m0_rresp   = (in_data && !grant) ? s_rresp : 2'b00;
        m1_rresp   = (in_data &&  grant) ? s_rresp : 2'b00;
        m0_rlast   = in_data && !grant && s_rlast;
        m1_rlast   = in_data &&  grant && s_rlast;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter with a behavioural AXI RAM slave
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int DW = 32;
    localparam int AW = 30;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]    m0_arlen, m1_arlen, s_arlen;
    logic [2:0]    m0_arsize, m1_arsize, s_arsize;
    logic [1:0]    m0_arburst, m1_arburst, s_arburst;
    logic          m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]    m0_rresp, m1_rresp, s_rresp;
    logic          m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic [IW-1:0] s_arid, s_rid;
    logic          s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, prot_err;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .prot_err(prot_err)
    );

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { int id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;

    beat_t exp0[$];
    beat_t exp1[$];
    ar_t   gq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    last_rlast_cyc = -1;
    int    cur_g = 0;
    int    early_at = -1;
    logic  chk_rready = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {2'b10, a} ^ 32'h0F0F_0000;
    endfunction

    always @(posedge clk) cyc++;

    // Slave model: samples handshakes on negedge, updates on posedge, drives outputs #1 later.
    initial begin
        logic          sl_busy, ar_hs, r_hs, r_last, sl_rst;
        logic [AW-1:0] sl_addr, a;
        logic [7:0]    sl_len;
        logic [IW-1:0] sl_id;
        int            sl_cnt;
        sl_busy = 1'b0; sl_addr = '0; sl_len = 8'd0; sl_id = '0; sl_cnt = 0;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rid = '0;
        forever begin
            @(negedge clk);
            sl_rst = !rst;
            ar_hs  = s_arvalid && s_arready;
            r_hs   = s_rvalid && s_rready;
            r_last = s_rlast;
            @(posedge clk);
            if (sl_rst) begin
                sl_busy = 1'b0;
            end else if (!sl_busy) begin
                if (ar_hs) begin
                    sl_busy = 1'b1; sl_addr = s_araddr; sl_len = s_arlen; sl_id = s_arid; sl_cnt = 0;
                end
            end else if (r_hs) begin
                if (r_last) sl_busy = 1'b0;
                else sl_cnt++;
            end
            #1;
            a         = sl_addr + AW'(4 * sl_cnt);
            s_arready = !sl_busy;
            s_rvalid  = sl_busy;
            s_rid     = sl_id;
            s_rlast   = sl_busy && ((sl_cnt == int'(sl_len)) || (sl_cnt == early_at));
            s_rdata   = sl_busy ? mem_word(a) : '0;
            s_rresp   = 2'b00;
        end
    end

    task automatic take_beat(input int m, input logic [DW-1:0] d, input logic l);
        beat_t b;
        check("r_owner", m, cur_g);
        if ((m == 0 && exp0.size() == 0) || (m == 1 && exp1.size() == 0)) begin
            check("beat_unexpected", m, 64'hFF);
        end else begin
            b = (m == 0) ? exp0.pop_front() : exp1.pop_front();
            check(m == 0 ? "m0_rdata" : "m1_rdata", d, b.data);
            check(m == 0 ? "m0_rlast" : "m1_rlast", l, b.last);
        end
        if (l) last_rlast_cyc = cyc;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (s_arvalid && s_arready) begin
                ar_t g;
                if (gq.size() == 0) begin
                    check("ar_unexpected", s_arid, 64'hFF);
                end else begin
                    g = gq.pop_front();
                    check("ar_id", s_arid, g.id);
                    check("ar_addr", s_araddr, g.addr);
                    check("ar_len", s_arlen, g.len);
                end
                if (last_rlast_cyc >= 0) check("ar_gap_ok", (cyc - last_rlast_cyc) >= 2, 1);
                cur_g = int'(s_arid);
            end
            if (m0_rvalid && m1_rvalid) check("both_rvalid", 1, 0);
            if (m0_rvalid && m0_rready) take_beat(0, m0_rdata, m0_rlast);
            if (m1_rvalid && m1_rready) take_beat(1, m1_rdata, m1_rlast);
            if (chk_rready && s_rvalid && cur_g == 0) check("rready_mirror", s_rready, m0_rready);
        end
    end

    task automatic master_req(input int m, input logic [AW-1:0] addr, input logic [7:0] len, input int nbeats);
        beat_t b;
        int    k;
        logic  rdy;
        for (int i = 0; i < nbeats; i++) begin
            b.data = mem_word(addr + AW'(4 * i));
            b.last = (i == nbeats - 1);
            if (m == 0) exp0.push_back(b);
            else        exp1.push_back(b);
        end
        if (m == 0) begin
            m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2; m0_arburst = 2'b01; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd2; m1_arburst = 2'b01; m1_arvalid = 1'b1;
        end
        k = 0;
        rdy = 1'b0;
        while (!rdy && k < 200) begin
            @(negedge clk);
            rdy = (m == 0) ? m0_arready : m1_arready;
            k++;
        end
        if (!rdy) check("ar_timeout", m, 64'hFF);
        @(posedge clk); #1;
        if (m == 0) m0_arvalid = 1'b0;
        else        m1_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp0.size() != 0 || exp1.size() != 0 || gq.size() != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) check("idle_timeout", exp0.size() + exp1.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b0;
        m0_araddr = '0; m0_arlen = 8'd0; m0_arsize = 3'd0; m0_arburst = 2'b00; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = '0; m1_arlen = 8'd0; m1_arsize = 3'd0; m1_arburst = 2'b00; m1_arvalid = 1'b0; m1_rready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready}, 6'b0);
        check("rst_prot_err", prot_err, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Both request out of reset: m0 first, then m1.
        gq.push_back('{0, 30'h200, 8'd3});
        gq.push_back('{1, 30'h300, 8'd3});
        fork
            master_req(0, 30'h200, 8'd3, 4);
            master_req(1, 30'h300, 8'd3, 4);
        join
        wait_idle();

        // Lone m1 request: one cycle of arbitration latency, single beat.
        gq.push_back('{1, 30'h100, 8'd0});
        fork
            master_req(1, 30'h100, 8'd0, 1);
            begin
                @(negedge clk);
                check("t1_arvalid_latency", s_arvalid, 0);
                @(negedge clk);
                check("t1_arvalid", s_arvalid, 1);
                check("t1_arid", s_arid, 1);
                check("t1_araddr", s_araddr, 30'h100);
            end
        join
        wait_idle();
        check("t1_prot_err", prot_err, 0);

        // Continuous requests from both: strict alternation.
        for (int i = 0; i < 3; i++) begin
            gq.push_back('{0, 30'h1000 + 30'(i * 64), 8'd1});
            gq.push_back('{1, 30'h2000 + 30'(i * 64), 8'd2});
        end
        fork
            for (int i = 0; i < 3; i++) master_req(0, 30'h1000 + 30'(i * 64), 8'd1, 2);
            for (int j = 0; j < 3; j++) master_req(1, 30'h2000 + 30'(j * 64), 8'd2, 3);
        join
        wait_idle();

        // m0 8-beat burst with toggling rready.
        chk_rready = 1'b1;
        gq.push_back('{0, 30'h4000, 8'd7});
        fork
            master_req(0, 30'h4000, 8'd7, 8);
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                m0_rready = (i % 2 == 1);
            end
        join
        m0_rready = 1'b1;
        wait_idle();
        chk_rready = 1'b0;
        check("t4_prot_err", prot_err, 0);

        // Early rlast on second beat of an arlen=3 burst.
        early_at = 1;
        gq.push_back('{0, 30'h5000, 8'd3});
        master_req(0, 30'h5000, 8'd3, 2);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m0_rvalid && m0_rready && m0_rlast) && k < 100);
        if (k >= 100) check("t5_rlast_timeout", k, 0);
        check("t5_err_before", prot_err, 0);
        @(negedge clk);
        check("t5_err_set", prot_err, 1);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", prot_err, 1);
        early_at = -1;
        wait_idle();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_err_cleared", prot_err, 0);
        @(posedge clk); #1;

        // Reset in the middle of a 4-beat burst.
        gq.push_back('{0, 30'h6000, 8'd3});
        master_req(0, 30'h6000, 8'd3, 4);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m0_rvalid && m0_rready) && k < 100);
        if (k >= 100) check("t6_beat_timeout", k, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        exp0.delete();
        @(negedge clk);
        check("t6_outputs_idle", {s_arvalid, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready}, 6'b0);
        check("t6_prot_err", prot_err, 0);
        @(posedge clk); #1;
        gq.push_back('{1, 30'h7000, 8'd2});
        master_req(1, 30'h7000, 8'd2, 3);
        wait_idle();
        check("t6_prot_err_end", prot_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
